// File: rtl/fight_game_pkg.sv
// Shared definitions for the player-action interface: action codes, pad bit
// indices, encoder FSM states and the per-pad priority encoder.
package fight_game_pkg;

   localparam logic [2:0] ACT_NOP    = 3'b000;
   localparam logic [2:0] ACT_LEFT   = 3'b001;
   localparam logic [2:0] ACT_RIGHT  = 3'b010;
   localparam logic [2:0] ACT_ATTACK = 3'b011;
   localparam logic [2:0] ACT_DEFEND = 3'b100;

   localparam int BTN_LEFT   = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_ATTACK = 2;
   localparam int BTN_DEFEND = 3;

   localparam int PAD_BITS        = 4;
   localparam int NUM_BUTTONS     = 2 * PAD_BITS + 1;
   localparam int BTN_CONFIRM_IDX = 2 * PAD_BITS;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_HOLD   = 2'd2
   } enc_state_e;

   // Simultaneous presses on one pad: attack > defend > left > right.
   function automatic logic [2:0] pad_to_action(input logic [PAD_BITS-1:0] press);
      logic [2:0] code;
      code = ACT_NOP;
      if (press[BTN_ATTACK])
         code = ACT_ATTACK;
      else if (press[BTN_DEFEND])
         code = ACT_DEFEND;
      else if (press[BTN_LEFT])
         code = ACT_LEFT;
      else if (press[BTN_RIGHT])
         code = ACT_RIGHT;
      return code;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// One pushbutton: 2-FF synchroniser, stability counter and a one-cycle press
// pulse on each accepted rising edge of the debounced level.
module button_debouncer #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_async,
   output logic level_o,
   output logic press_o
);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic [19:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn_async;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      // The counter only runs while the synchronised input disagrees with the
      // accepted level; a single agreeing sample restarts the qualification.
      if (sync2_q != level_q) begin
         if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 20'd1;
         end
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/action_input_encoder.sv
// Player-action producer: debounces both pads and CONFIRM, keeps pending moves
// and commits them with an actionEnable strobe. CONFIRM_REPEAT_EN adds re-strobing while CONFIRM is held.
module action_input_encoder
   import fight_game_pkg::*;
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter int          STROBE_CYCLES   = 4,
   parameter logic [24:0] REPEAT_CYCLES   = 25'd25000000
) (
   input  logic       clk,
   input  logic       resetGame,
   input  logic [3:0] btn1,
   input  logic [3:0] btn2,
   input  logic       btnConfirm,
   output logic [2:0] action1,
   output logic [2:0] action2,
   output logic       actionEnable,
   output logic       ready1,
   output logic       ready2
);

   localparam int SCW = $clog2(STROBE_CYCLES + 1);

   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n_int;

   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge clk or negedge resetGame) begin
      if (!resetGame)
         rst_sync_q <= '0;
      else
         rst_sync_q <= rst_sync_d;
   end

   // Assertion follows resetGame immediately; release is retimed to clk.
   assign rst_n_int = rst_sync_q[1];

   logic [NUM_BUTTONS-1:0] btn_raw, level_w, press_w;

   assign btn_raw = {btnConfirm, btn2, btn1};

   generate
      for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_deb
         button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n_int),
            .btn_async(btn_raw[gi]),
            .level_o  (level_w[gi]),
            .press_o  (press_w[gi])
         );
      end
   endgenerate

   // Only CONFIRM's held level matters; pad levels are consumed as pulses.
   logic unused_pad_levels;
   assign unused_pad_levels = &{1'b0, level_w[NUM_BUTTONS-2:0]};

   enc_state_e     state_q, state_d;
   logic [SCW-1:0] strobe_cnt_q, strobe_cnt_d;
   logic [2:0]     pend1_q, pend1_d;
   logic [2:0]     pend2_q, pend2_d;
   logic [2:0]     act1_q, act1_d;
   logic [2:0]     act2_q, act2_d;
   logic           en_q, en_d;

   logic [2:0]     pad1_code, pad2_code;
   logic           confirm_press, confirm_level, any_ready, commit;

   assign pad1_code     = pad_to_action(press_w[PAD_BITS-1:0]);
   assign pad2_code     = pad_to_action(press_w[2*PAD_BITS-1:PAD_BITS]);
   assign confirm_press = press_w[BTN_CONFIRM_IDX];
   assign confirm_level = level_w[BTN_CONFIRM_IDX];
   assign any_ready     = (pend1_q != ACT_NOP) || (pend2_q != ACT_NOP);

`ifdef CONFIRM_REPEAT_EN
   logic [24:0] rep_cnt_q, rep_cnt_d;
   logic        rep_expired;

   always_comb begin
      rep_expired = (rep_cnt_q == REPEAT_CYCLES - 25'd1);
      rep_cnt_d   = '0;
      if ((state_q == ST_HOLD) && confirm_level && !rep_expired)
         rep_cnt_d = rep_cnt_q + 25'd1;
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int)
         rep_cnt_q <= '0;
      else
         rep_cnt_q <= rep_cnt_d;
   end
`endif

   always_comb begin
      state_d      = state_q;
      strobe_cnt_d = strobe_cnt_q;
      pend1_d      = pend1_q;
      pend2_d      = pend2_q;
      act1_d       = act1_q;
      act2_d       = act2_q;
      commit       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (confirm_press && any_ready)
               commit = 1'b1;
         end
         ST_STROBE: begin
            // Count 0 is the setup cycle; counts 1..STROBE_CYCLES drive the strobe.
            if (strobe_cnt_q == SCW'(STROBE_CYCLES))
               state_d = ST_HOLD;
            else
               strobe_cnt_d = strobe_cnt_q + SCW'(1);
         end
         ST_HOLD: begin
            if (!confirm_level)
               state_d = ST_IDLE;
`ifdef CONFIRM_REPEAT_EN
            else if (rep_expired && any_ready)
               commit = 1'b1;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (commit) begin
         state_d      = ST_STROBE;
         strobe_cnt_d = '0;
         act1_d       = pend1_q;
         act2_d       = pend2_q;
         pend1_d      = ACT_NOP;
         pend2_d      = ACT_NOP;
      end

      // A press arriving with the commit is applied after the clear.
      if (pad1_code != ACT_NOP)
         pend1_d = pad1_code;
      if (pad2_code != ACT_NOP)
         pend2_d = pad2_code;

      en_d = (state_q == ST_STROBE) && (strobe_cnt_q != SCW'(STROBE_CYCLES));
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q      <= ST_IDLE;
         strobe_cnt_q <= '0;
         pend1_q      <= ACT_NOP;
         pend2_q      <= ACT_NOP;
         act1_q       <= ACT_NOP;
         act2_q       <= ACT_NOP;
         en_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         strobe_cnt_q <= strobe_cnt_d;
         pend1_q      <= pend1_d;
         pend2_q      <= pend2_d;
         act1_q       <= act1_d;
         act2_q       <= act2_d;
         en_q         <= en_d;
      end
   end

   assign action1      = act1_q;
   assign action2      = act2_q;
   assign actionEnable = en_q;
   assign ready1       = (pend1_q != ACT_NOP);
   assign ready2       = (pend2_q != ACT_NOP);

endmodule

// File: tb/tb_action_input_encoder.sv
// Randomized and directed bench for action_input_encoder against a
// cycle-level behavioural model built from the button/commit rules.
module tb_action_input_encoder;

   localparam int DC = 4;
   localparam int SC = 2;
   localparam int RC = 16;
   localparam int PRIO_BIT  [4] = '{2, 3, 0, 1};
   localparam int PRIO_CODE [4] = '{3, 4, 1, 2};

   logic       clk = 1'b0;
   logic       resetGame;
   logic [3:0] btn1, btn2;
   logic       btnConfirm;
   logic [2:0] action1, action2;
   logic       actionEnable, ready1, ready2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   action_input_encoder #(
      .DEBOUNCE_CYCLES(20'd4),
      .STROBE_CYCLES  (SC),
      .REPEAT_CYCLES  (25'd16)
   ) dut (
      .clk         (clk),
      .resetGame   (resetGame),
      .btn1        (btn1),
      .btn2        (btn2),
      .btnConfirm  (btnConfirm),
      .action1     (action1),
      .action2     (action2),
      .actionEnable(actionEnable),
      .ready1      (ready1),
      .ready2      (ready2)
   );

   // ---------------- behavioural model ----------------
   int       m_rel = 0;
   bit [8:0] m_raw[$];
   bit [8:0] m_win[$];
   bit [8:0] m_lvl = '0;
   bit [8:0] m_ppress = '0;
   int       m_left = 0;
   bit       m_holding = 1'b0;
   int       m_hold_cyc = 0;
   int       m_pend1 = 0, m_pend2 = 0, m_act1 = 0, m_act2 = 0;

   function automatic int pad_code(input bit [3:0] p);
      for (int i = 0; i < 4; i++)
         if (p[PRIO_BIT[i]]) return PRIO_CODE[i];
      return 0;
   endfunction

   task automatic model_clear();
      m_raw.delete();
      m_win.delete();
      m_lvl = '0;
      m_ppress = '0;
      m_left = 0;
      m_holding = 1'b0;
      m_hold_cyc = 0;
      m_pend1 = 0; m_pend2 = 0; m_act1 = 0; m_act2 = 0;
   endtask

   task automatic model_update();
      bit [8:0] s2, np;
      bit       oc, all_opp, commit;
      int       c1, c2;
      if (!resetGame) begin
         m_rel = 0;
         model_clear();
      end else if (m_rel < 2) begin
         m_rel++;
         model_clear();
      end else begin
         // The debouncer sees each button value two clocks after it was sampled.
         s2 = (m_raw.size() >= 2) ? m_raw[m_raw.size()-2] : 9'd0;
         m_raw.push_back({btnConfirm, btn2, btn1});
         if (m_raw.size() > 3) void'(m_raw.pop_front());
         m_win.push_back(s2);
         if (m_win.size() > DC) void'(m_win.pop_front());
         oc = m_lvl[8];
         np = '0;
         for (int b = 0; b < 9; b++) begin
            if (m_win.size() == DC) begin
               all_opp = 1'b1;
               foreach (m_win[i]) if (m_win[i][b] == m_lvl[b]) all_opp = 1'b0;
               if (all_opp) begin
                  m_lvl[b] = ~m_lvl[b];
                  np[b]    = m_lvl[b];
               end
            end
         end
         c1 = pad_code(m_ppress[3:0]);
         c2 = pad_code(m_ppress[7:4]);
         commit = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_holding  = 1'b1;
               m_hold_cyc = 0;
            end
         end else if (m_holding) begin
            if (!oc) begin
               m_holding = 1'b0;
            end else begin
               m_hold_cyc++;
               if (m_hold_cyc == RC) begin
                  m_hold_cyc = 0;
`ifdef CONFIRM_REPEAT_EN
                  if (m_pend1 != 0 || m_pend2 != 0) commit = 1'b1;
`endif
               end
            end
         end else if (m_ppress[8] && (m_pend1 != 0 || m_pend2 != 0)) begin
            commit = 1'b1;
         end
         if (commit) begin
            m_act1 = m_pend1; m_act2 = m_pend2;
            m_pend1 = 0; m_pend2 = 0;
            m_left = SC + 1;
            m_holding = 1'b0;
         end
         if (c1 != 0) m_pend1 = c1;
         if (c2 != 0) m_pend2 = c2;
         m_ppress = np;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge resetGame);
      model_update();
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("enable",  int'(actionEnable), (m_left > 0 && m_left <= SC) ? 1 : 0);
      check_eq("action1", int'(action1), m_act1);
      check_eq("action2", int'(action2), m_act2);
      check_eq("ready1",  int'(ready1), (m_pend1 != 0) ? 1 : 0);
      check_eq("ready2",  int'(ready2), (m_pend2 != 0) ? 1 : 0);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         check_outputs();
      end
   endtask

   task automatic select_pad(input int pad, input bit [3:0] mask);
      if (pad == 1) btn1 = mask; else btn2 = mask;
      cycles(10);
      if (pad == 1) btn1 = '0; else btn2 = '0;
      cycles(10);
   endtask

   task automatic count_strobes(input int n, input int release_at, output int highs, output int rises);
      bit prev;
      prev = 1'b0; highs = 0; rises = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         check_outputs();
         highs += int'(actionEnable);
         if (actionEnable && !prev) rises++;
         prev = actionEnable;
         if (i == release_at) btnConfirm = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      resetGame = 1'b0;
      #1;
      check_outputs();
      cycles(n);
      resetGame = 1'b1;
   endtask

   initial begin
      int       highs, rises;
      bit       seen;
      bit [8:0] v;
      resetGame = 1'b1; btn1 = '0; btn2 = '0; btnConfirm = 1'b0;
      #1 resetGame = 1'b0;
      #1;
      check_eq("rst_enable", int'(actionEnable), 0);
      check_eq("rst_action1", int'(action1), 0);
      check_eq("rst_action2", int'(action2), 0);
      check_eq("rst_ready1", int'(ready1), 0);
      check_eq("rst_ready2", int'(ready2), 0);
      cycles(3);
      resetGame = 1'b1;
      cycles(5);

      // 1: attack on pad 1, then confirm
      btn1[2] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         check_outputs();
         if (i == 6) check_eq("t1_ready_before", int'(ready1), 0);
         if (i == 7) check_eq("t1_ready_at7", int'(ready1), 1);
      end
      btn1[2] = 1'b0;
      cycles(10);
      btnConfirm = 1'b1;
      highs = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         check_outputs();
         highs += int'(actionEnable);
         if (i == 7) begin
            check_eq("t1_setup_enable", int'(actionEnable), 0);
            check_eq("t1_action1", int'(action1), 3);
            check_eq("t1_action2", int'(action2), 0);
         end
         if (i == 8) check_eq("t1_enable_rise", int'(actionEnable), 1);
         if (i == 10) btnConfirm = 1'b0;
      end
      check_eq("t1_strobe_len", highs, 2);
      check_eq("t1_ready_after", int'(ready1), 0);
      cycles(10);

      // 2: glitch on pad 2 left
      btn2[0] = 1'b1;
      cycles(3);
      btn2[0] = 1'b0;
      cycles(15);
      check_eq("t2_glitch_ready2", int'(ready2), 0);

      // 3: right+defend together, then attack on pad 2
      select_pad(1, 4'b1010);
      select_pad(2, 4'b0100);
      btnConfirm = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         check_outputs();
         if (i == 8) begin
            check_eq("t3_action1_defend", int'(action1), 4);
            check_eq("t3_action2_attack", int'(action2), 3);
         end
      end
      btnConfirm = 1'b0;
      cycles(15);

      // 4: confirm with nothing pending
      btnConfirm = 1'b1;
      count_strobes(30, 10, highs, rises);
      check_eq("t4_no_strobe", highs, 0);
      cycles(10);

      // 5: async reset in the first strobe cycle
      select_pad(1, 4'b0001);
      btnConfirm = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         check_outputs();
         if (actionEnable) seen = 1'b1;
      end
      check_eq("t5_strobe_seen", int'(seen), 1);
      resetGame = 1'b0;
      btnConfirm = 1'b0;
      #1;
      check_eq("t5_enable_dropped", int'(actionEnable), 0);
      check_eq("t5_action1", int'(action1), 0);
      check_eq("t5_ready1", int'(ready1), 0);
      check_outputs();
      cycles(3);
      resetGame = 1'b1;
      cycles(10);
      btnConfirm = 1'b1;
      count_strobes(30, 10, highs, rises);
      check_eq("t5_no_strobe_after", highs, 0);
      cycles(10);

      // 6: hold confirm, reselect between strobes
      select_pad(1, 4'b0100);
      btnConfirm = 1'b1;
      rises = 0;
      begin
         bit prev;
         prev = 1'b0;
         for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            check_outputs();
            if (actionEnable && !prev) rises++;
            prev = actionEnable;
            if (i == 22) begin btn1[0] = 1'b1; btn2[3] = 1'b1; end
            if (i == 30) begin btn1 = '0; btn2 = '0; end
            if (i == 60) btnConfirm = 1'b0;
         end
      end
`ifdef CONFIRM_REPEAT_EN
      check_eq("t6_strobe_count", rises, 2);
`else
      check_eq("t6_strobe_count", rises, 1);
`endif
      cycles(10);

      // random activity on all nine buttons with occasional resets
      v = '0;
      for (int it = 0; it < 250; it++) begin
         for (int b = 0; b < 9; b++)
            if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
         {btnConfirm, btn2, btn1} = v;
         cycles($urandom_range(1, 10));
         if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 4));
      end
      {btnConfirm, btn2, btn1} = '0;
      cycles(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
